memu_scheduler: RTL
===================

# memu_scheduler

Schedules the single data-memory port between speculative loads issued by the load/store buffer and committed stores drained from the ROB head. Computes effective addresses, checks bounds and stalls loads that alias pending stores. Sequences the registered DM read/write enables and returns load results to the CDB through a valid/ready handshake. Sits between LdStB/ROB commit and the DM block.

## Interface
- ROB_SIZE_BITS, 4, ROBEN width is ROB_SIZE_BITS+1.
- MEMORY_SIZE, 4096, words of data memory.
- MEMORY_BITS, 12, address bits compared/forwarded.
- SQ_DEPTH, 4, store drain queue entries (power of 2).
- LATENCY, 1, DM read latency in cycles (1..3).

- clk in 1: clock, all state on rising edge.
- rst in 1: reset, asynchronous, active-high.
- flush in 1: ROB mispredict flush (synchronous).
- ld_valid/ld_ready in/out 1: load request handshake.
- ld_roben in ROB_SIZE_BITS+1: load tag.
- ld_base, ld_imm in 32: operand and offset.
- st_valid/st_ready in/out 1: committed-store handshake.
- st_base, st_imm, st_data in 32: store operands.
- st_invalid_address out 1: one-cycle pulse, rejected store.
- mem_read_en, mem_write_en out 1: DM enables (registered).
- mem_address, mem_data out 32: DM address/write data (registered).
- mem_roben out ROB_SIZE_BITS+1: tag of issued load.
- mem_result in 32: DM read data.
- cdb_valid/cdb_ready out/in 1: result handshake.
- cdb_roben out ROB_SIZE_BITS+1, cdb_result out 32, cdb_invalid_address out 1.

## Operation
- EA = base + imm, 32-bit wrap. Invalid when EA > MEMORY_SIZE-1 (unsigned).
- Store path: accepted when st_valid & st_ready. st_ready = queue not full. Valid EA → enqueue {EA[MEMORY_BITS-1:0], data}. Invalid → not enqueued; st_invalid_address pulses the next cycle.
- Load FSM: L_IDLE, L_WAIT, L_RESP.
- L_IDLE: ld_ready = !flush & !hazard & !queue_full.
  - hazard = EA[MEMORY_BITS-1:0] matches any valid queue entry or a store being accepted this cycle.
  - Accepted valid load: issue the read, go to L_WAIT.
  - Accepted invalid load: no DM access. Go to L_RESP with cdb_invalid_address=1 and cdb_result=0.
- L_WAIT: count LATENCY cycles after the issue cycle. Capture mem_result, go to L_RESP.
- L_RESP: cdb_valid=1. On cdb_ready go to L_IDLE. ld_ready=0.
- Port arbitration, one op per cycle:
  - Queue full → store drains and ld_ready=0.
  - Otherwise an accepted load wins.
  - Otherwise the queue head drains if non-empty.
  - Stores never drain in the load's issue cycle.
- flush: forces L_IDLE, drops any pending or in-flight load response. The queue is untouched because its stores are committed. A read already issued completes harmlessly.

## Timing
- Reset: every output 0, FSM L_IDLE, queue empty, latency counter 0.
- Load accepted at edge E: mem_read_en=1 and mem_address=EA in cycle E+1. cdb_valid=1 in cycle E+1+LATENCY.
- Invalid load accepted at E: cdb_valid=1 in cycle E+1.
- Store issue: mem_write_en=1 for exactly one cycle per entry, FIFO order. Dequeue occurs at the same edge that sets mem_write_en.
- Simultaneous enqueue and dequeue while full: enqueue is refused (st_ready=0), dequeue proceeds.
- Enqueue and dequeue on a non-full, non-empty queue: both occur, count unchanged.
- cdb outputs are held stable while cdb_valid & !cdb_ready.
- flush and cdb_ready in the same cycle: flush wins, no new load accepted that cycle.
- rst mid-operation clears state immediately. Dropped queued stores are acceptable only because reset implies a full-core restart.

## Structure
- Package memu_pkg: MEMORY_SIZE, MEMORY_BITS, ROB_SIZE_BITS, the load FSM state enum and the store queue entry typedef.
- Sub-module store_drain_fifo: circular buffer with head/tail pointers plus a count. Exposes full, empty and head, and a per-entry valid/address vector for hazard comparison.

## Test plan
- Load base=100, imm=4, roben=5, mem_result=0xDEAD → mem_read_en with mem_address=104 one cycle after accept. Then cdb_valid with roben=5 and result 0xDEAD after LATENCY more cycles.
- Load base=4090, imm=6 → no mem_read_en. cdb_valid next cycle with cdb_invalid_address=1 and result 0.
- Store to 200, data=7, then load EA=200 while the store is queued → ld_ready=0 until mem_write_en to 200. The load issues afterwards and reads 7.
- Four stores enqueued with a load pending → st_ready=0 at 4 entries and ld_ready=0. The queue drains one entry per cycle, then the load issues.
- cdb_ready held low 3 cycles in L_RESP → cdb outputs stable, ld_ready=0. Handshake completes on the 4th cycle.
- flush during L_WAIT → no cdb_valid for that load. Next load is accepted in the following cycle. rst asserted mid-L_WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/memu_pkg.sv
// Shared sizes, load FSM states and the store drain queue entry for the
// memory-unit scheduler.
package memu_pkg;
  localparam int ROB_SIZE_BITS = 4;
  localparam int MEMORY_SIZE   = 4096;
  localparam int MEMORY_BITS   = 12;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_RESP
  } ld_state_e;

  typedef struct packed {
    logic [MEMORY_BITS-1:0] addr;
    logic [31:0]            data;
  } sq_entry_t;

  // An effective address is usable only if it falls inside data memory.
  function automatic logic ea_in_range(input logic [31:0] ea);
    return ea <= 32'(MEMORY_SIZE - 1);
  endfunction
endpackage

// File: rtl/store_drain_fifo.sv
// Circular store drain queue; exposes the head plus every slot's valid bit and
// address so the scheduler can detect load/store aliasing.
module store_drain_fifo
  import memu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push_i,
  input  sq_entry_t                           push_data_i,
  input  logic                                pop_i,
  output logic                                full_o,
  output logic                                empty_o,
  output sq_entry_t                           head_o,
  output logic [DEPTH-1:0]                    vld_o,
  output logic [DEPTH-1:0][MEMORY_BITS-1:0]   addr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  sq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [PW:0]     cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + ONE;
        2'b01:   cnt_q <= cnt_q - ONE;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[head_q];

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off       = PW'(i) - head_q;
    assign vld_o[i]  = ({1'b0, off} < cnt_q);
    assign addr_o[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/memu_scheduler.sv
// Arbitrates the single data-memory port between speculative loads and
// committed store drains, and returns load results over the CDB handshake.
module memu_scheduler
  import memu_pkg::*;
#(
  parameter int SQ_DEPTH = 4,
  parameter int LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ROB_SIZE_BITS:0] ld_roben,
  input  logic [31:0]            ld_base,
  input  logic [31:0]            ld_imm,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_base,
  input  logic [31:0]            st_imm,
  input  logic [31:0]            st_data,
  output logic                   st_invalid_address,
  output logic                   mem_read_en,
  output logic                   mem_write_en,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_data,
  output logic [ROB_SIZE_BITS:0] mem_roben,
  input  logic [31:0]            mem_result,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [ROB_SIZE_BITS:0] cdb_roben,
  output logic [31:0]            cdb_result,
  output logic                   cdb_invalid_address
);
  ld_state_e                          state_q;
  logic [1:0]                         cnt_q;
  logic                               live_q;
  logic                               st_inv_q, rd_en_q, wr_en_q;
  logic [31:0]                        addr_q, data_q;
  logic [ROB_SIZE_BITS:0]             mem_roben_q, cdb_roben_q;
  logic                               cdb_valid_q, cdb_inv_q;
  logic [31:0]                        cdb_result_q;

  logic [31:0]                        st_ea, ld_ea;
  logic                               st_ok, ld_ok, st_acc, enq, ld_acc, deq, hazard;
  logic                               sq_full, sq_empty;
  sq_entry_t                          sq_head, sq_push;
  logic [SQ_DEPTH-1:0]                sq_vld;
  logic [SQ_DEPTH-1:0][MEMORY_BITS-1:0] sq_addr;

  assign st_ea   = st_base + st_imm;
  assign ld_ea   = ld_base + ld_imm;
  assign st_ok   = ea_in_range(st_ea);
  assign ld_ok   = ea_in_range(ld_ea);
  assign sq_push = '{addr: st_ea[MEMORY_BITS-1:0], data: st_data};

  // Handshakes stay low while reset is held and for the first cycle after it.
  assign st_ready = live_q & ~sq_full;
  assign st_acc   = st_valid & st_ready;
  assign enq      = st_acc & st_ok;

  always_comb begin
    hazard = enq && (st_ea[MEMORY_BITS-1:0] == ld_ea[MEMORY_BITS-1:0]);
    for (int i = 0; i < SQ_DEPTH; i++)
      if (sq_vld[i] && sq_addr[i] == ld_ea[MEMORY_BITS-1:0]) hazard = 1'b1;
  end

  assign ld_ready = live_q & (state_q == L_IDLE) & ~flush & ~hazard & ~sq_full;
  assign ld_acc   = ld_valid & ld_ready;
  assign deq      = ~sq_empty & ~ld_acc;

  store_drain_fifo #(.DEPTH(SQ_DEPTH)) u_sq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (enq),
    .push_data_i (sq_push),
    .pop_i       (deq),
    .full_o      (sq_full),
    .empty_o     (sq_empty),
    .head_o      (sq_head),
    .vld_o       (sq_vld),
    .addr_o      (sq_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= L_IDLE;
      cnt_q        <= '0;
      live_q       <= 1'b0;
      st_inv_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mem_roben_q  <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_roben_q  <= '0;
      cdb_result_q <= '0;
      cdb_inv_q    <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      st_inv_q <= st_acc & ~st_ok;
      rd_en_q  <= ld_acc & ld_ok;
      wr_en_q  <= deq;
      if (ld_acc && ld_ok) begin
        addr_q      <= ld_ea;
        mem_roben_q <= ld_roben;
      end else if (deq) begin
        addr_q <= 32'(sq_head.addr);
        data_q <= sq_head.data;
      end
      unique case (state_q)
        L_IDLE: if (ld_acc) begin
          cdb_roben_q <= ld_roben;
          if (ld_ok) begin
            cnt_q   <= 2'(LATENCY - 1);
            state_q <= L_WAIT;
          end else begin
            cdb_valid_q  <= 1'b1;
            cdb_result_q <= '0;
            cdb_inv_q    <= 1'b1;
            state_q      <= L_RESP;
          end
        end
        // A flushed read still completes at the DM; its data is simply ignored.
        L_WAIT: if (flush) begin
          cnt_q   <= '0;
          state_q <= L_IDLE;
        end else if (cnt_q == '0) begin
          cdb_valid_q  <= 1'b1;
          cdb_result_q <= mem_result;
          cdb_inv_q    <= 1'b0;
          state_q      <= L_RESP;
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
        L_RESP: if (flush || cdb_ready) begin
          cdb_valid_q <= 1'b0;
          state_q     <= L_IDLE;
        end
        default: state_q <= L_IDLE;
      endcase
    end
  end

  assign st_invalid_address  = st_inv_q;
  assign mem_read_en         = rd_en_q;
  assign mem_write_en        = wr_en_q;
  assign mem_address         = addr_q;
  assign mem_data            = data_q;
  assign mem_roben           = mem_roben_q;
  assign cdb_valid           = cdb_valid_q;
  assign cdb_roben           = cdb_roben_q;
  assign cdb_result          = cdb_result_q;
  assign cdb_invalid_address = cdb_inv_q;
endmodule
